alu_share_arbiter: RTL and testbench

Shares one `mips_alu` instance between two requesters, such as the integer issue path and the branch-compare path, using round-robin arbitration. Each requester uses a valid/ready handshake. The block has a two-stage pipeline: an operand register, then a result register. Responses carry the winner id and a caller tag back to the consumer through a valid/ready response port with full backpressure.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/mips_alu.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes and the request record that is
//               carried through the shared-ALU operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 4-bit ALU control codes understood by mips_alu
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_EQ  = 4'd3;
    localparam logic [3:0] ALU_GE  = 4'd4;
    localparam logic [3:0] ALU_GT  = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLE = 4'd8;
    localparam logic [3:0] ALU_SLL = 4'd10;
    localparam logic [3:0] ALU_SRL = 4'd11;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Widest caller tag the request record can carry; narrower tags are
    // zero-extended into it and truncated back on the way out.
    localparam int ALU_TAG_MAX_W = 16;

    typedef struct packed {
        logic [3:0]               ctrl;
        logic [31:0]              a;
        logic [31:0]              b;
        logic [4:0]               shamt;
        logic [ALU_TAG_MAX_W-1:0] tag;
    } alu_req_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu
// Description : Purely combinational 32-bit ALU with unsigned compares,
//               logical shifts and a zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu
    import alu_pkg::*;
(
    input  logic [3:0]  i_ctrl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [31:0] w_diff;

    assign w_diff = i_a - i_b;

    // Operation select; unassigned codes produce zero
    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = w_diff;
            ALU_EQ:  o_result = {31'd0, (w_diff == 32'd0)};
            ALU_GE:  o_result = {31'd0, (i_a >= i_b)};
            ALU_GT:  o_result = {31'd0, (i_a > i_b)};
            ALU_SLT: o_result = {31'd0, (i_a < i_b)};
            ALU_SLE: o_result = {31'd0, (i_a <= i_b)};
            ALU_SLL: o_result = i_b << i_shamt;
            ALU_SRL: o_result = i_b >> i_shamt;
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
        o_zero = (o_result == 32'd0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one mips_alu between two valid/ready
//               requesters through an operand register and a response
//               register with full response backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_shamt,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    logic             w_s2_free;
    logic             w_s1_free;
    logic             w_winner;
    logic             w_win_valid;
    logic             w_accept;
    alu_req_t         w_req0;
    alu_req_t         w_req1;
    alu_req_t         w_req_win;
    logic [31:0]      w_alu_result;
    logic             w_alu_zero;

    logic             r_prio;
    logic             r_s1_valid;
    logic             r_s1_id;
    alu_req_t         r_s1;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [31:0]      r_rsp_result;
    logic             r_rsp_zero;

    assign w_req0 = '{ctrl: req0_ctrl, a: req0_a, b: req0_b, shamt: req0_shamt,
                      tag: ALU_TAG_MAX_W'(req0_tag)};
    assign w_req1 = '{ctrl: req1_ctrl, a: req1_a, b: req1_b, shamt: req1_shamt,
                      tag: ALU_TAG_MAX_W'(req1_tag)};

    // Stage availability: a stage frees up when empty or when it drains this cycle
    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    // Lone requester wins; on contention the priority pointer decides
    assign w_winner    = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign w_win_valid = w_winner ? req1_valid : req0_valid;
    assign w_req_win   = w_winner ? w_req1 : w_req0;

    // Readies are forced low while reset is asserted
    assign req0_ready = rst_n && w_s1_free && !w_winner;
    assign req1_ready = rst_n && w_s1_free &&  w_winner;
    assign w_accept   = rst_n && w_s1_free && w_win_valid;

    // Priority pointer moves to the other requester after every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_winner;
        end
    end

    // Operand register: refills (or empties) whenever its content can leave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1    <= w_req_win;
                r_s1_id <= w_winner;
            end
        end
    end

    mips_alu u_alu (
        .i_ctrl   (r_s1.ctrl),
        .i_a      (r_s1.a),
        .i_b      (r_s1.b),
        .i_shamt  (r_s1.shamt),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // Response register: holds its payload while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_s2_free) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_id     <= r_s1_id;
                r_rsp_tag    <= r_s1.tag[TAG_W-1:0];
                r_rsp_result <= w_alu_result;
                r_rsp_zero   <= w_alu_zero;
            end
        end
    end

    // Tag bits above TAG_W are always zero and intentionally dropped
    generate
        if (TAG_W < ALU_TAG_MAX_W) begin : g_tag_pad
            logic w_unused_tag_bits;
            assign w_unused_tag_bits = |r_s1.tag[ALU_TAG_MAX_W-1:TAG_W];
        end
    endgenerate

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = r_s1_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed bench for alu_share_arbiter: table of single ALU
//               operations plus contention, backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0; req0_shamt = 0; req0_tag = 0;
        req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0; req1_shamt = 0; req1_tag = 0;
        rsp_ready  = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        req0_valid = 1;
        req1_valid = 1;
        #1;
        check("reset req0_ready", {31'd0, req0_ready}, 0);
        check("reset req1_ready", {31'd0, req1_ready}, 0);
        repeat (2) @(posedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic drive0(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [3:0] t);
        req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; req0_shamt = sh; req0_tag = t;
    endtask

    task automatic drive1(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [3:0] t);
        req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; req1_shamt = sh; req1_tag = t;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic [3:0] t1;
        logic [3:0] exp_tag [4];
        logic       exp_id  [4];

        vecs[0]  = '{4'd0,  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  32'h00F0000F, 1'b0};
        vecs[1]  = '{4'd1,  32'hF0000000, 32'h0000000F, 5'd0,  32'hF000000F, 1'b0};
        vecs[2]  = '{4'd2,  32'd5,        32'd7,        5'd0,  32'd12,       1'b0};
        vecs[3]  = '{4'd2,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1};
        vecs[4]  = '{4'd6,  32'd10,       32'd3,        5'd0,  32'd7,        1'b0};
        vecs[5]  = '{4'd6,  32'd3,        32'd10,       5'd0,  32'hFFFFFFF9, 1'b0};
        vecs[6]  = '{4'd3,  32'd5,        32'd5,        5'd0,  32'd1,        1'b0};
        vecs[7]  = '{4'd3,  32'd5,        32'd6,        5'd0,  32'd0,        1'b1};
        vecs[8]  = '{4'd4,  32'd7,        32'd7,        5'd0,  32'd1,        1'b0};
        vecs[9]  = '{4'd4,  32'd0,        32'd1,        5'd0,  32'd0,        1'b1};
        vecs[10] = '{4'd5,  32'd7,        32'd7,        5'd0,  32'd0,        1'b1};
        vecs[11] = '{4'd5,  32'd8,        32'd7,        5'd0,  32'd1,        1'b0};
        vecs[12] = '{4'd7,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1};
        vecs[13] = '{4'd7,  32'd1,        32'd2,        5'd0,  32'd1,        1'b0};
        vecs[14] = '{4'd8,  32'd2,        32'd2,        5'd0,  32'd1,        1'b0};
        vecs[15] = '{4'd8,  32'd3,        32'd2,        5'd0,  32'd0,        1'b1};
        vecs[16] = '{4'd10, 32'd0,        32'd1,        5'd31, 32'h80000000, 1'b0};
        vecs[17] = '{4'd11, 32'd0,        32'h80000000, 5'd31, 32'd1,        1'b0};
        vecs[18] = '{4'd11, 32'd0,        32'h000000F0, 5'd4,  32'h0000000F, 1'b0};
        vecs[19] = '{4'd12, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[20] = '{4'd12, 32'hFFFF0000, 32'h0000FFFF, 5'd0,  32'd0,        1'b1};
        vecs[21] = '{4'd9,  32'd123,      32'd456,      5'd3,  32'd0,        1'b1};
        vecs[22] = '{4'd13, 32'hFFFFFFFF, 32'd1,        5'd1,  32'd0,        1'b1};
        vecs[23] = '{4'd15, 32'd77,       32'd99,       5'd0,  32'd0,        1'b1};

        rst_n = 0;
        clear_inputs();
        do_reset();
        check("reset rsp_valid",  {31'd0, rsp_valid}, 0);
        check("reset busy",       {31'd0, busy},      0);
        check("reset rsp_result", rsp_result,         0);
        check("reset rsp_zero",   {31'd0, rsp_zero},  0);
        check("reset rsp_id",     {31'd0, rsp_id},    0);
        check("reset rsp_tag",    {28'd0, rsp_tag},   0);

        // Single ADD: handshake at cycle 0, response visible at cycle 2
        drive0(1, 4'd2, 32'd5, 32'd7, 5'd0, 4'd3);
        #1;
        check("add req0_ready", {31'd0, req0_ready}, 1);
        tick();
        drive0(0, 4'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        check("add cycle1 rsp_valid", {31'd0, rsp_valid}, 0);
        check("add cycle1 busy",      {31'd0, busy},      1);
        tick();
        check("add rsp_valid",  {31'd0, rsp_valid}, 1);
        check("add rsp_result", rsp_result,         32'd12);
        check("add rsp_zero",   {31'd0, rsp_zero},  0);
        check("add rsp_id",     {31'd0, rsp_id},    0);
        check("add rsp_tag",    {28'd0, rsp_tag},   3);
        tick();

        // Table of single operations through requester 0
        for (int i = 0; i < NVEC; i++) begin
            drive0(1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, 4'(i));
            #1;
            check($sformatf("vec%0d ready", i), {31'd0, req0_ready}, 1);
            tick();
            drive0(0, 4'd0, 32'd0, 32'd0, 5'd0, 4'd0);
            tick();
            check($sformatf("vec%0d rsp_valid", i), {31'd0, rsp_valid}, 1);
            check($sformatf("vec%0d result", i),    rsp_result,         vecs[i].res);
            check($sformatf("vec%0d zero", i),      {31'd0, rsp_zero},  {31'd0, vecs[i].z});
            check($sformatf("vec%0d tag", i),       {28'd0, rsp_tag},   {28'd0, 4'(i)});
        end
        tick();

        // Contention: both valid for 4 cycles from reset, grants alternate from 0
        do_reset();
        c0 = 0;
        c1 = 0;
        exp_id[0] = 0; exp_tag[0] = 4'h0;
        exp_id[1] = 1; exp_tag[1] = 4'h8;
        exp_id[2] = 0; exp_tag[2] = 4'h1;
        exp_id[3] = 1; exp_tag[3] = 4'h9;
        for (int k = 0; k < 7; k++) begin
            if (k >= 2 && k < 6) begin
                check($sformatf("cont rsp%0d valid", k - 2), {31'd0, rsp_valid}, 1);
                check($sformatf("cont rsp%0d id", k - 2),    {31'd0, rsp_id},    {31'd0, exp_id[k-2]});
                check($sformatf("cont rsp%0d tag", k - 2),   {28'd0, rsp_tag},   {28'd0, exp_tag[k-2]});
            end
            if (k == 6) check("cont drained", {31'd0, rsp_valid}, 0);
            drive0(k < 4, 4'd2, 32'(c0), 32'd0, 5'd0, 4'(c0));
            drive1(k < 4, 4'd2, 32'(c1), 32'd0, 5'd0, 4'h8 + 4'(c1));
            #1;
            if (k < 4) begin
                check($sformatf("cont grant%0d r0", k), {31'd0, req0_ready}, (k % 2 == 0) ? 1 : 0);
                check($sformatf("cont grant%0d r1", k), {31'd0, req1_ready}, (k % 2 == 1) ? 1 : 0);
            end
            if (req0_valid && req0_ready) c0++;
            if (req1_valid && req1_ready) c1++;
            tick();
        end

        // Backpressure: req1 streams SUB 10-3 while the consumer stalls
        do_reset();
        t1 = 4'd1;
        for (int k = 0; k < 9; k++) begin
            rsp_ready = (k >= 5);
            drive1(k <= 5, 4'd6, 32'd10, 32'd3, 5'd0, t1);
            #1;
            if (k <= 5)
                check($sformatf("bp k%0d req1_ready", k), {31'd0, req1_ready},
                      (k < 2 || k == 5) ? 1 : 0);
            if (k < 2) check($sformatf("bp k%0d rsp_valid", k), {31'd0, rsp_valid}, 0);
            if (k >= 2 && k <= 5) begin
                check($sformatf("bp k%0d rsp_valid", k), {31'd0, rsp_valid}, 1);
                check($sformatf("bp k%0d result", k),    rsp_result,         32'd7);
                check($sformatf("bp k%0d tag", k),       {28'd0, rsp_tag},   1);
            end
            if (k == 4) begin
                check("bp full req0_ready", {31'd0, req0_ready}, 0);
                check("bp full busy",       {31'd0, busy},       1);
            end
            if (k == 6) begin
                check("bp drain2 valid", {31'd0, rsp_valid}, 1);
                check("bp drain2 tag",   {28'd0, rsp_tag},   2);
            end
            if (k == 7) check("bp drain3 tag", {28'd0, rsp_tag}, 3);
            if (k == 8) check("bp empty", {31'd0, rsp_valid}, 0);
            if (req1_valid && req1_ready) t1 = t1 + 4'd1;
            tick();
        end

        // Reset with both stages full, then a fresh request afterwards
        do_reset();
        rsp_ready = 0;
        drive0(1, 4'd2, 32'd1, 32'd2, 5'd0, 4'd5);
        #1;
        check("mid acc0 ready", {31'd0, req0_ready}, 1);
        tick();
        drive0(1, 4'd2, 32'd1, 32'd2, 5'd0, 4'd6);
        #1;
        check("mid acc1 ready", {31'd0, req0_ready}, 1);
        tick();
        check("mid full busy",  {31'd0, busy},       1);
        check("mid full ready", {31'd0, req0_ready}, 0);
        rst_n = 0;
        #1;
        check("mid rst rsp_valid", {31'd0, rsp_valid},  0);
        check("mid rst busy",      {31'd0, busy},       0);
        check("mid rst ready0",    {31'd0, req0_ready}, 0);
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
        check("post rst rsp_valid", {31'd0, rsp_valid}, 0);
        drive0(1, 4'd2, 32'd1, 32'd1, 5'd0, 4'hA);
        drive1(1, 4'd6, 32'd9, 32'd4, 5'd0, 4'hB);
        #1;
        check("post rst prio r0", {31'd0, req0_ready}, 1);
        check("post rst prio r1", {31'd0, req1_ready}, 0);
        tick();
        drive0(0, 4'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        #1;
        check("post rst r1 ready", {31'd0, req1_ready}, 1);
        check("post rst no stale", {31'd0, rsp_valid},  0);
        tick();
        drive1(0, 4'd0, 32'd0, 32'd0, 5'd0, 4'd0);
        check("post rst rsp0 valid",  {31'd0, rsp_valid}, 1);
        check("post rst rsp0 id",     {31'd0, rsp_id},    0);
        check("post rst rsp0 tag",    {28'd0, rsp_tag},   32'hA);
        check("post rst rsp0 result", rsp_result,         32'd2);
        tick();
        check("post rst rsp1 id",     {31'd0, rsp_id},    1);
        check("post rst rsp1 tag",    {28'd0, rsp_tag},   32'hB);
        check("post rst rsp1 result", rsp_result,         32'd5);
        tick();
        check("post rst empty", {31'd0, rsp_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
